axis_packet_arbiter: RTL and testbench

Packet-granular arbiter that shares one AXI4-Stream output (typically feeding an `axis_register_slice` or a downstream FIFO) among `N_REQ` AXI4-Stream requesters. Grants are issued round-robin and held for a whole packet, until the beat with `tlast` is accepted, so packets from different sources never interleave. The payload path is a combinational mux selected by a registered grant. All control state lives in a small two-state FSM.

---
 rtl/axis_packet_arbiter_if.sv | 51 +++++
 rtl/axis_packet_arbiter.sv | 140 ++++++++++++++
 tb/tb_axis_packet_arbiter.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/axis_packet_arbiter_if.sv
// AXI4-Stream config type and stream interface shared by axis_packet_arbiter and its users.
package axis_pkg;

  typedef struct packed {
    int unsigned N;
    int unsigned I;
    int unsigned D;
    int unsigned U;
    logic        USE_TSTRB;
    logic        USE_TKEEP;
  } axis_cfg_t;

  localparam axis_cfg_t AXIS_CFG_DEFAULT = '{N: 1, I: 1, D: 1, U: 1, USE_TSTRB: 1'b0, USE_TKEEP: 1'b0};

  // Zero-width sideband fields are carried as a single tied bit.
  function automatic int unsigned w1(input int unsigned x);
    return (x == 0) ? 1 : x;
  endfunction

endpackage

interface axis_if #(
  parameter axis_pkg::axis_cfg_t CFG = axis_pkg::AXIS_CFG_DEFAULT
);
  localparam int unsigned DW = CFG.N * 8;
  localparam int unsigned KW = CFG.N;
  localparam int unsigned IW = axis_pkg::w1(CFG.I);
  localparam int unsigned EW = axis_pkg::w1(CFG.D);
  localparam int unsigned UW = axis_pkg::w1(CFG.U);

  logic [DW-1:0] tdata;
  logic [KW-1:0] tstrb;
  logic [KW-1:0] tkeep;
  logic [IW-1:0] tid;
  logic [EW-1:0] tdest;
  logic [UW-1:0] tuser;
  logic          tlast;
  logic          tvalid;
  logic          tready;

  modport master (
    output tdata, tstrb, tkeep, tid, tdest, tuser, tlast, tvalid,
    input  tready
  );

  modport slave (
    input  tdata, tstrb, tkeep, tid, tdest, tuser, tlast, tvalid,
    output tready
  );

endinterface

// File: rtl/axis_packet_arbiter.sv
// Packet-locked round-robin arbiter sharing one AXI4-Stream output among N_REQ sources.
// Optional build macro AXIS_PACKET_ARBITER_PRIORITY0_EN makes requester 0 strict high priority.
module axis_packet_arbiter
  import axis_pkg::*;
#(
  parameter axis_cfg_t   CONFIG = AXIS_CFG_DEFAULT,
  parameter int unsigned N_REQ  = 4,
  localparam int unsigned GW    = $clog2(N_REQ)
) (
  input  logic          aclk,
  input  logic          reset,
  axis_if.slave         axis_in [N_REQ],
  axis_if.master        axis_out,
  output logic [GW-1:0] grant_idx,
  output logic          busy
);

  localparam int unsigned DW = CONFIG.N * 8;
  localparam int unsigned KW = CONFIG.N;
  localparam int unsigned IW = w1(CONFIG.I);
  localparam int unsigned EW = w1(CONFIG.D);
  localparam int unsigned UW = w1(CONFIG.U);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [GW-1:0]   r_grant;
  logic [GW-1:0]   w_grant_nxt;
  logic [GW-1:0]   r_ptr;
  logic [GW-1:0]   w_ptr_nxt;
  logic [GW-1:0]   w_rr_win;

  logic [N_REQ-1:0] w_valid;
  logic [N_REQ-1:0] w_tlast;
  logic [N_REQ-1:0] w_cand;
  logic [DW-1:0]    w_tdata [N_REQ];
  logic [KW-1:0]    w_tstrb [N_REQ];
  logic [KW-1:0]    w_tkeep [N_REQ];
  logic [IW-1:0]    w_tid   [N_REQ];
  logic [EW-1:0]    w_tdest [N_REQ];
  logic [UW-1:0]    w_tuser [N_REQ];

  logic w_busy;
  logic w_out_valid;
  logic w_end_pkt;

  assign w_busy      = (r_state == S_BUSY);
  assign w_out_valid = w_busy & w_valid[r_grant];
  assign w_end_pkt   = w_out_valid & axis_out.tready & w_tlast[r_grant];

  // Unpack the interface array so the granted source can be selected by a runtime index.
  for (genvar i = 0; i < N_REQ; i++) begin : g_req
    assign w_valid[i] = axis_in[i].tvalid;
    assign w_tlast[i] = axis_in[i].tlast;
    assign w_tdata[i] = axis_in[i].tdata;
    assign w_tstrb[i] = axis_in[i].tstrb;
    assign w_tkeep[i] = axis_in[i].tkeep;
    assign w_tid[i]   = axis_in[i].tid;
    assign w_tdest[i] = axis_in[i].tdest;
    assign w_tuser[i] = axis_in[i].tuser;
    assign axis_in[i].tready = w_busy & (r_grant == GW'(i)) & axis_out.tready;
  end

  assign axis_out.tvalid = w_out_valid;
  assign axis_out.tlast  = w_tlast[r_grant];
  assign axis_out.tdata  = w_tdata[r_grant];
  assign axis_out.tstrb  = w_tstrb[r_grant];
  assign axis_out.tkeep  = w_tkeep[r_grant];
  assign axis_out.tid    = w_tid[r_grant];
  assign axis_out.tdest  = w_tdest[r_grant];
  assign axis_out.tuser  = w_tuser[r_grant];

  assign grant_idx = r_grant;
  assign busy      = w_busy;

`ifdef AXIS_PACKET_ARBITER_PRIORITY0_EN
  // Requester 0 is served outside the rotation, so it never enters the round-robin search.
  assign w_cand = {w_valid[N_REQ-1:1], 1'b0};
`else
  assign w_cand = w_valid;
`endif

  // First candidate after the pointer, wrapping modulo N_REQ.
  always_comb begin : p_rr_search
    logic found;
    found    = 1'b0;
    w_rr_win = r_ptr;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      if (!found && w_cand[GW'((32'(r_ptr) + k) % N_REQ)]) begin
        found    = 1'b1;
        w_rr_win = GW'((32'(r_ptr) + k) % N_REQ);
      end
    end
  end

  always_comb begin : p_fsm_next
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      S_IDLE: begin
        if (|w_valid) begin
          w_state_nxt = S_BUSY;
`ifdef AXIS_PACKET_ARBITER_PRIORITY0_EN
          if (w_valid[0]) begin
            w_grant_nxt = '0;
          end else begin
            w_grant_nxt = w_rr_win;
            w_ptr_nxt   = w_rr_win;
          end
`else
          w_grant_nxt = w_rr_win;
          w_ptr_nxt   = w_rr_win;
`endif
        end
      end
      S_BUSY: begin
        if (w_end_pkt) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin : p_fsm_reg
    if (reset) begin
      r_state <= S_IDLE;
      r_grant <= GW'(N_REQ - 1);
      r_ptr   <= GW'(N_REQ - 1);
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

endmodule

// File: tb/tb_axis_packet_arbiter.sv
// Self-checking bench for axis_packet_arbiter: per-cycle vector table plus packet-level sequences.
module tb_axis_packet_arbiter;
  import axis_pkg::*;

  localparam axis_cfg_t   CFG = '{N: 1, I: 2, D: 2, U: 1, USE_TSTRB: 1'b1, USE_TKEEP: 1'b1};
  localparam int unsigned NR  = 4;
  localparam int unsigned NV  = 30;

  logic       clk;
  logic       rst;
  logic       cnt_clr;
  logic [3:0] src_v;
  logic [3:0] src_l;
  logic [3:0] src_rdy;
  logic       snk_rdy;
  logic [3:0] cnt [NR];
  logic [1:0] grant_idx;
  logic       busy;

  int n_checks;
  int n_errors;
  logic [3:0] obs_src [$];

  axis_if #(.CFG(CFG)) axis_in [NR] ();
  axis_if #(.CFG(CFG)) axis_out ();

  // Source i emits {i, running beat count} so every output beat names its origin.
  for (genvar i = 0; i < NR; i++) begin : g_src
    assign axis_in[i].tvalid = src_v[i];
    assign axis_in[i].tlast  = src_l[i];
    assign axis_in[i].tdata  = {4'(i), cnt[i]};
    assign axis_in[i].tstrb  = 1'b1;
    assign axis_in[i].tkeep  = 1'b1;
    assign axis_in[i].tid    = 2'(i);
    assign axis_in[i].tdest  = 2'(3 - i);
    assign axis_in[i].tuser  = 1'(i);
    assign src_rdy[i]        = axis_in[i].tready;
  end

  assign axis_out.tready = snk_rdy;

  axis_packet_arbiter #(.CONFIG(CFG), .N_REQ(NR)) dut (
    .aclk      (clk),
    .reset     (rst),
    .axis_in   (axis_in),
    .axis_out  (axis_out),
    .grant_idx (grant_idx),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    for (int i = 0; i < NR; i++) begin
      if (cnt_clr) cnt[i] <= 4'd0;
      else if (src_v[i] && src_rdy[i]) cnt[i] <= cnt[i] + 4'd1;
    end
  end

  typedef struct {
    logic       rst;
    logic [3:0] v;
    logic [3:0] l;
    logic       rdy;
    logic       e_busy;
    logic [1:0] e_gnt;
    logic       e_ov;
    logic [7:0] e_od;
    logic       e_ol;
    logic [3:0] e_tr;
  } vec_t;

  vec_t vecs [NV];

  function automatic vec_t mk(input logic r, input logic [3:0] v, input logic [3:0] l, input logic rdy,
                              input logic eb, input logic [1:0] eg, input logic eov, input logic [7:0] eod,
                              input logic eol, input logic [3:0] etr);
    vec_t x;
    x.rst = r; x.v = v; x.l = l; x.rdy = rdy;
    x.e_busy = eb; x.e_gnt = eg; x.e_ov = eov; x.e_od = eod; x.e_ol = eol; x.e_tr = etr;
    return x;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reset, then run until nbeats output beats are seen; tlast closes every packet of 'beats' beats.
  task automatic run_seq(input logic [3:0] v, input int unsigned beats, input int unsigned nbeats,
                         output int unsigned cycles);
    int unsigned pbeat;
    obs_src.delete();
    pbeat  = 0;
    cycles = 0;
    @(negedge clk);
    rst = 1'b1; src_v = v; src_l = 4'h0; snk_rdy = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    while (obs_src.size() < nbeats && cycles < 200) begin
      src_l = (pbeat == beats - 1) ? 4'hF : 4'h0;
      #1;
      if (axis_out.tvalid && axis_out.tready) begin
        obs_src.push_back(axis_out.tdata[7:4]);
        pbeat = (pbeat == beats - 1) ? 0 : pbeat + 1;
      end
      @(negedge clk);
      cycles++;
    end
    chk("seq_beats", 32'(obs_src.size()), 32'(nbeats));
  endtask

  initial begin
    int unsigned cyc;
    int unsigned exp_src;
    n_checks = 0;
    n_errors = 0;

    // State at start of each cycle, inputs for that cycle, outputs expected before the edge.
    vecs[0]  = mk(1, 4'b1111, 4'b0000, 1, 0, 2'd3, 0, 8'h00, 0, 4'b0000);
    vecs[1]  = mk(0, 4'b0100, 4'b0000, 1, 0, 2'd3, 0, 8'h00, 0, 4'b0000);
    vecs[2]  = mk(0, 4'b0100, 4'b0000, 1, 1, 2'd2, 1, 8'h20, 0, 4'b0100);
    vecs[3]  = mk(0, 4'b0100, 4'b0000, 1, 1, 2'd2, 1, 8'h21, 0, 4'b0100);
    vecs[4]  = mk(0, 4'b0100, 4'b0000, 1, 1, 2'd2, 1, 8'h22, 0, 4'b0100);
    vecs[5]  = mk(0, 4'b0100, 4'b0100, 1, 1, 2'd2, 1, 8'h23, 1, 4'b0100);
    vecs[6]  = mk(0, 4'b0000, 4'b0000, 1, 0, 2'd2, 0, 8'h00, 0, 4'b0000);
    vecs[7]  = mk(0, 4'b1111, 4'b1111, 1, 0, 2'd2, 0, 8'h00, 0, 4'b0000);
    vecs[8]  = mk(0, 4'b1111, 4'b1111, 1, 1, 2'd3, 1, 8'h30, 1, 4'b1000);
    vecs[9]  = mk(0, 4'b1111, 4'b1111, 1, 0, 2'd3, 0, 8'h00, 0, 4'b0000);
    vecs[10] = mk(0, 4'b1111, 4'b1111, 1, 1, 2'd0, 1, 8'h00, 1, 4'b0001);
    vecs[11] = mk(0, 4'b1111, 4'b1111, 1, 0, 2'd0, 0, 8'h00, 0, 4'b0000);
    vecs[12] = mk(0, 4'b1111, 4'b1111, 1, 1, 2'd1, 1, 8'h10, 1, 4'b0010);
    vecs[13] = mk(0, 4'b1111, 4'b0000, 1, 0, 2'd1, 0, 8'h00, 0, 4'b0000);
    vecs[14] = mk(0, 4'b1111, 4'b0000, 0, 1, 2'd2, 1, 8'h24, 0, 4'b0000);
    vecs[15] = mk(0, 4'b1111, 4'b0000, 0, 1, 2'd2, 1, 8'h24, 0, 4'b0000);
    vecs[16] = mk(0, 4'b1111, 4'b0000, 0, 1, 2'd2, 1, 8'h24, 0, 4'b0000);
    vecs[17] = mk(0, 4'b1111, 4'b0000, 1, 1, 2'd2, 1, 8'h24, 0, 4'b0100);
    vecs[18] = mk(0, 4'b1011, 4'b0000, 1, 1, 2'd2, 0, 8'h00, 0, 4'b0100);
    vecs[19] = mk(0, 4'b1011, 4'b0000, 1, 1, 2'd2, 0, 8'h00, 0, 4'b0100);
    vecs[20] = mk(0, 4'b1111, 4'b0100, 1, 1, 2'd2, 1, 8'h25, 1, 4'b0100);
    vecs[21] = mk(0, 4'b1111, 4'b0000, 1, 0, 2'd2, 0, 8'h00, 0, 4'b0000);
    vecs[22] = mk(0, 4'b1111, 4'b0000, 1, 1, 2'd3, 1, 8'h31, 0, 4'b1000);
    vecs[23] = mk(1, 4'b1111, 4'b0000, 1, 1, 2'd3, 1, 8'h32, 0, 4'b1000);
    vecs[24] = mk(0, 4'b1111, 4'b0000, 1, 0, 2'd3, 0, 8'h00, 0, 4'b0000);
    vecs[25] = mk(0, 4'b1111, 4'b0000, 1, 1, 2'd0, 1, 8'h01, 0, 4'b0001);
    vecs[26] = mk(0, 4'b0011, 4'b0001, 1, 1, 2'd0, 1, 8'h02, 1, 4'b0001);
    vecs[27] = mk(0, 4'b0011, 4'b0000, 1, 0, 2'd0, 0, 8'h00, 0, 4'b0000);
    vecs[28] = mk(0, 4'b0011, 4'b0010, 1, 1, 2'd1, 1, 8'h11, 1, 4'b0010);
    vecs[29] = mk(0, 4'b0000, 4'b0000, 1, 0, 2'd1, 0, 8'h00, 0, 4'b0000);

    rst = 1'b1; cnt_clr = 1'b1; src_v = 4'hF; src_l = 4'h0; snk_rdy = 1'b1;
    repeat (2) @(posedge clk);
    cnt_clr = 1'b0;

    for (int t = 0; t < NV; t++) begin
      @(negedge clk);
      rst = vecs[t].rst; src_v = vecs[t].v; src_l = vecs[t].l; snk_rdy = vecs[t].rdy;
      #1;
      chk($sformatf("v%0d_busy", t),   32'(busy),            32'(vecs[t].e_busy));
      chk($sformatf("v%0d_grant", t),  32'(grant_idx),       32'(vecs[t].e_gnt));
      chk($sformatf("v%0d_tvalid", t), 32'(axis_out.tvalid), 32'(vecs[t].e_ov));
      chk($sformatf("v%0d_tready", t), 32'(src_rdy),         32'(vecs[t].e_tr));
      if (vecs[t].e_ov) begin
        chk($sformatf("v%0d_tdata", t), 32'(axis_out.tdata), 32'(vecs[t].e_od));
        chk($sformatf("v%0d_tlast", t), 32'(axis_out.tlast), 32'(vecs[t].e_ol));
        chk($sformatf("v%0d_tid", t),   32'(axis_out.tid),   32'(vecs[t].e_gnt));
      end
    end

    // All four sources saturated, 3-beat packets: grant order and one bubble per packet.
    run_seq(4'b1111, 3, 24, cyc);
    chk("fair_cycles", 32'(cyc), 32'd32);
    for (int b = 0; b < 24; b++) begin
`ifdef AXIS_PACKET_ARBITER_PRIORITY0_EN
      exp_src = 0;
`else
      exp_src = (b / 3) % 4;
`endif
      if (b < obs_src.size()) chk($sformatf("fair_beat%0d_src", b), 32'(obs_src[b]), 32'(exp_src));
    end

    // Sources 0 and 1 saturated with single-beat packets.
    run_seq(4'b0011, 1, 4, cyc);
    chk("prio_cycles", 32'(cyc), 32'd8);
    for (int b = 0; b < 4; b++) begin
`ifdef AXIS_PACKET_ARBITER_PRIORITY0_EN
      exp_src = 0;
`else
      exp_src = b % 2;
`endif
      if (b < obs_src.size()) chk($sformatf("prio_pkt%0d_src", b), 32'(obs_src[b]), 32'(exp_src));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
